knn_topk_select: RTL and testbench
==================================

// Module: knn_topk_select
// PURPOSE
//  Consumes the per-vertex squared-distance stream from the distance stage and keeps
//  the K smallest distances of the current query, with their vertex IDs, in a table
//  sorted ascending (one insertion per cycle). At query end it drains the table,
//  nearest first, over a valid/ready port to the result/visit logic.
// PARAMETERS
//  K         4   entries kept (>=2); result_rank_out is $clog2(K) bits
//  ID_WIDTH  16  vertex identifier width
// PORTS
//  clk_in            in   1         system clock
//  rst_in            in   1         synchronous active-high reset
//  query_start_in    in   1         pulse: clear table, begin new query
//  query_done_in     in   1         pulse: no more candidates for this query
//  data_valid_in     in   1         candidate valid (single-cycle pulse from distance stage)
//  distance_sq_in    in   32        unsigned squared distance
//  vertex_id_in      in   ID_WIDTH  vertex ID paired with distance_sq_in
//  result_valid_out  out  1         result beat valid
//  result_ready_in   in   1         consumer accepts beat
//  result_dist_out   out  32        distance of current beat
//  result_id_out     out  ID_WIDTH  vertex ID of current beat
//  result_rank_out   out  clog2(K)  0 = nearest
//  result_last_out   out  1         final beat of this query
//  fill_count_out    out  clog2(K+1) valid entries in table (saturates at K)
//  busy_out          out  1         high in COLLECT or DRAIN
//  done_out          out  1         one-cycle pulse when query result fully delivered
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; table entries invalid, dist=32'hFFFF_FFFF, id=0.
//  States: IDLE -> COLLECT on query_start_in. COLLECT -> COLLECT (restart) on
//   query_start_in (priority over query_done_in). COLLECT -> DRAIN on query_done_in when
//   fill>0; COLLECT -> IDLE on query_done_in when fill==0, pulsing done_out next cycle.
//   DRAIN -> IDLE after handshake (valid&&ready) of beat with result_last_out=1;
//   done_out pulses the cycle after that handshake.
//  Insertion (COLLECT, data_valid_in=1): parallel compare against all entries; new entry
//   placed at first position p where dist_in < entry[p].dist (strict: ties keep older
//   entry first); entries p..K-2 shift down, entry K-1 discarded. If table full and
//   dist_in >= entry[K-1].dist, candidate dropped. Table updated at the sampling edge;
//   fill_count_out reflects it the next cycle. One candidate per cycle, no backpressure.
//  No duplicate-ID filtering; the same ID may occupy multiple entries.
//  Candidate in same cycle as query_done_in: inserted before drain begins.
//  Candidate or query_done_in in IDLE: ignored. Any input except result_ready_in and
//   rst_in ignored in DRAIN (query_start_in in DRAIN is dropped, not queued).
//  Drain: result_valid_out high from the first DRAIN cycle; beat r presents entry[r],
//   rank r; result_last_out when r==fill-1. Outputs held stable while valid&&!ready.
//   Beats advance one per handshake; zero bubbles when ready held high.
//  Latency: query_done_in at edge N -> first beat valid in cycle N+1.
//  rst_in mid-COLLECT or mid-DRAIN: immediate return to reset state, no done_out.
//  Distances are unsigned 32-bit compares; 32'hFFFF_FFFF is a legal insertable value
//   (validity tracked by per-entry valid bit, not sentinel).
// TESTING
//  1 K=4: start; insert (d,id)=(50,1),(10,2),(30,3),(20,4),(40,5); done; ready=1 ->
//    beats (10,2,r0),(20,4,r1),(30,3,r2),(40,1? no:50 dropped)=(40,5,r3,last); done_out.
//  2 Ties: insert (7,A),(7,B) -> drain order A then B; fill_count_out=2.
//  3 Empty query: start then done with no candidates -> no result_valid_out; done_out
//    pulses cycle after done; busy_out low.
//  4 Backpressure: 3 entries, ready toggles 1,0,0,1,1 -> beats stable while stalled,
//    exactly 3 handshakes, last on third, done_out once.
//  5 Boundaries: candidate with done same cycle is included; start+done same cycle ->
//    table cleared, stays COLLECT; 32'hFFFF_FFFF inserted into non-full table appears.
//  6 rst_in asserted during drain beat 1 -> all outputs 0 next cycle, no done_out;
//    new query afterwards returns fresh results only.

Source files
------------

// File: rtl/knn_topk_select.sv
// -----------------------------------------------------------------------------
// knn_topk_select
//
// Keeps the K nearest candidates of one k-NN query. Squared distances arrive
// from the distance stage at up to one per cycle; each one is compared in
// parallel against a table held sorted ascending and, if it belongs in the
// top K, is inserted in a single cycle. When the query ends the table is
// drained nearest-first over a valid/ready port.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   query_start_in    pulse: clear the table and begin a new query
//   query_done_in     pulse: no more candidates for the current query
//   data_valid_in     candidate valid (single-cycle pulse)
//   distance_sq_in    unsigned 32-bit squared distance of the candidate
//   vertex_id_in      vertex ID paired with distance_sq_in
//   result_valid_out  result beat valid
//   result_ready_in   consumer accepts the current beat
//   result_dist_out   distance of the current beat
//   result_id_out     vertex ID of the current beat
//   result_rank_out   rank of the current beat (0 = nearest)
//   result_last_out   final beat of this query
//   fill_count_out    number of valid table entries (saturates at K)
//   busy_out          high while collecting or draining
//   done_out          one-cycle pulse once the query result is fully delivered
// -----------------------------------------------------------------------------
module knn_topk_select #(
  parameter int K        = 4,
  parameter int ID_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   query_start_in,
  input  logic                   query_done_in,
  input  logic                   data_valid_in,
  input  logic [31:0]            distance_sq_in,
  input  logic [ID_WIDTH-1:0]    vertex_id_in,
  output logic                   result_valid_out,
  input  logic                   result_ready_in,
  output logic [31:0]            result_dist_out,
  output logic [ID_WIDTH-1:0]    result_id_out,
  output logic [$clog2(K)-1:0]   result_rank_out,
  output logic                   result_last_out,
  output logic [$clog2(K+1)-1:0] fill_count_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam int RANK_W = $clog2(K);
  localparam int FILL_W = $clog2(K + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Sorted table: entry 0 is the nearest. Valid entries are always packed
  // at the low indices, so ent_valid reads as a thermometer code.
  logic [31:0]         ent_dist  [K];
  logic [ID_WIDTH-1:0] ent_id    [K];
  logic [K-1:0]        ent_valid;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [FILL_W-1:0]   rd_idx_q;
  logic                done_q, done_d;

  logic [K-1:0]        goes_before;  // candidate sorts strictly ahead of entry i
  logic                accept;       // candidate earns a place in the table
  logic                table_clear;
  logic                ins_en;
  logic                handshake;

  // ---------------------------------------------------------------------------
  // Parallel compare. An empty slot always accepts, so 32'hFFFF_FFFF is
  // insertable. Strict less-than keeps equal-distance older entries first.
  // Because the table is sorted, goes_before is monotonic: once set at index
  // i it stays set for every higher index.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < K; i++) begin
      goes_before[i] = !ent_valid[i] || (distance_sq_in < ent_dist[i]);
    end
  end

  // The last slot accepts exactly when the candidate belongs anywhere.
  assign accept    = goes_before[K-1];
  assign handshake = result_valid_out && result_ready_in;

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    table_clear = 1'b0;
    ins_en      = 1'b0;
    done_d      = 1'b0;
    fill_d      = fill_q;

    unique case (state_q)
      IDLE: begin
        if (query_start_in) begin
          state_d     = COLLECT;
          table_clear = 1'b1;
        end
      end

      COLLECT: begin
        if (query_start_in) begin
          // Restart wins over a coincident query_done_in.
          table_clear = 1'b1;
        end else begin
          // A candidate arriving with query_done_in is still inserted.
          ins_en = data_valid_in && accept;
          if (ins_en && !ent_valid[K-1]) begin
            fill_d = fill_q + FILL_W'(1);
          end
          if (query_done_in) begin
            if (fill_d != '0) begin
              state_d = DRAIN;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        if (handshake && result_last_out) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (table_clear) begin
      fill_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      fill_q   <= '0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
      if (state_q != DRAIN) begin
        rd_idx_q <= '0;
      end else if (handshake) begin
        rd_idx_q <= rd_idx_q + FILL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Table storage with single-cycle insert-and-shift. Slot i takes the
  // candidate when it is the first slot the candidate beats, or takes the old
  // slot i-1 when the candidate also beat i-1. The old last entry falls off.
  // ---------------------------------------------------------------------------
  // NOTE: the table is reset explicitly because it is only K entries of flops,
  // and downstream logic expects invalid entries to read dist=all-ones, id=0.
  always_ff @(posedge clk_in) begin
    if (rst_in || table_clear) begin
      for (int i = 0; i < K; i++) begin
        ent_dist[i] <= '1;
        ent_id[i]   <= '0;
      end
      ent_valid <= '0;
    end else if (ins_en) begin
      if (goes_before[0]) begin
        ent_dist[0]  <= distance_sq_in;
        ent_id[0]    <= vertex_id_in;
        ent_valid[0] <= 1'b1;
      end
      for (int i = 1; i < K; i++) begin
        if (goes_before[i-1]) begin
          ent_dist[i]  <= ent_dist[i-1];
          ent_id[i]    <= ent_id[i-1];
          ent_valid[i] <= ent_valid[i-1];
        end else if (goes_before[i]) begin
          ent_dist[i]  <= distance_sq_in;
          ent_id[i]    <= vertex_id_in;
          ent_valid[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Beats come straight from the table indexed by the read pointer,
  // so they are naturally stable while the consumer stalls. Outside DRAIN the
  // result port is forced to zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    result_valid_out = (state_q == DRAIN);
    result_dist_out  = '0;
    result_id_out    = '0;
    result_rank_out  = '0;
    result_last_out  = 1'b0;
    if (result_valid_out) begin
      result_dist_out = ent_dist[rd_idx_q[RANK_W-1:0]];
      result_id_out   = ent_id[rd_idx_q[RANK_W-1:0]];
      result_rank_out = rd_idx_q[RANK_W-1:0];
      result_last_out = (rd_idx_q == fill_q - FILL_W'(1));
    end
  end

  assign fill_count_out = fill_q;
  assign busy_out       = (state_q != IDLE);
  assign done_out       = done_q;

endmodule

// File: tb/tb_knn_topk_select.sv
// -----------------------------------------------------------------------------
// tb_knn_topk_select
//
// Directed and randomized checks of knn_topk_select (K=4, ID_WIDTH=16). The
// reference is a queue of (distance, id) pairs kept sorted by inserting each
// candidate ahead of the first strictly larger distance and trimming to K.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_knn_topk_select;

  localparam int K        = 4;
  localparam int ID_WIDTH = 16;

  typedef struct packed {
    logic [31:0]         d;
    logic [ID_WIDTH-1:0] id;
  } ent_t;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic                   query_start_in;
  logic                   query_done_in;
  logic                   data_valid_in;
  logic [31:0]            distance_sq_in;
  logic [ID_WIDTH-1:0]    vertex_id_in;
  logic                   result_valid_out;
  logic                   result_ready_in;
  logic [31:0]            result_dist_out;
  logic [ID_WIDTH-1:0]    result_id_out;
  logic [$clog2(K)-1:0]   result_rank_out;
  logic                   result_last_out;
  logic [$clog2(K+1)-1:0] fill_count_out;
  logic                   busy_out;
  logic                   done_out;

  int   errors = 0;
  int   checks = 0;
  ent_t model[$];

  knn_topk_select #(.K(K), .ID_WIDTH(ID_WIDTH)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .query_start_in   (query_start_in),
    .query_done_in    (query_done_in),
    .data_valid_in    (data_valid_in),
    .distance_sq_in   (distance_sq_in),
    .vertex_id_in     (vertex_id_in),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .result_dist_out  (result_dist_out),
    .result_id_out    (result_id_out),
    .result_rank_out  (result_rank_out),
    .result_last_out  (result_last_out),
    .fill_count_out   (fill_count_out),
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference top-K: insert before the first strictly larger distance.
  function automatic void model_insert(input logic [31:0] d, input logic [ID_WIDTH-1:0] id);
    int p = model.size();
    for (int i = 0; i < model.size(); i++) begin
      if (d < model[i].d) begin
        p = i;
        break;
      end
    end
    model.insert(p, ent_t'{d, id});
    if (model.size() > K) void'(model.pop_back());
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, result_valid_out, 0);
    check({tag, "_dist"},  result_dist_out,  0);
    check({tag, "_id"},    result_id_out,    0);
    check({tag, "_rank"},  result_rank_out,  0);
    check({tag, "_last"},  result_last_out,  0);
    check({tag, "_fill"},  fill_count_out,   0);
    check({tag, "_busy"},  busy_out,         0);
    check({tag, "_done"},  done_out,         0);
  endtask

  task automatic start_query();
    query_start_in = 1'b1;
    step();
    query_start_in = 1'b0;
    model.delete();
    check("start_fill", fill_count_out, 0);
    check("start_busy", busy_out, 1);
  endtask

  task automatic send(input logic [31:0] d, input logic [ID_WIDTH-1:0] id);
    data_valid_in  = 1'b1;
    distance_sq_in = d;
    vertex_id_in   = id;
    step();
    data_valid_in  = 1'b0;
    model_insert(d, id);
    check("send_fill", fill_count_out, model.size());
  endtask

  task automatic end_query();
    query_done_in = 1'b1;
    step();
    query_done_in = 1'b0;
  endtask

  // Drains and checks every beat against the model. ready follows pat for the
  // first plen cycles, then stays high. With poke set, inputs that must be
  // ignored in DRAIN are thrown at the DUT on drain cycle 1.
  task automatic drain(input logic [31:0] pat, input int plen, input bit poke);
    int r   = 0;
    int cyc = 0;
    while (r < model.size() && cyc < 100) begin
      result_ready_in = (cyc < plen) ? pat[cyc] : 1'b1;
      if (poke && cyc == 1) begin
        query_start_in = 1'b1;
        query_done_in  = 1'b1;
        data_valid_in  = 1'b1;
        distance_sq_in = 32'd0;
        vertex_id_in   = 16'hDEAD;
      end
      check("beat_valid", result_valid_out, 1);
      check("beat_dist",  result_dist_out,  model[r].d);
      check("beat_id",    result_id_out,    model[r].id);
      check("beat_rank",  result_rank_out,  r);
      check("beat_last",  result_last_out,  (r == model.size() - 1));
      check("beat_busy",  busy_out,         1);
      check("beat_done",  done_out,         0);
      step();
      query_start_in = 1'b0;
      query_done_in  = 1'b0;
      data_valid_in  = 1'b0;
      if (result_ready_in) r++;
      cyc++;
    end
    if (cyc >= 100) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: delivered=%0d required=%0d", r, model.size());
    end
    result_ready_in = 1'b0;
    check("end_valid", result_valid_out, 0);
    check("end_busy",  busy_out,         0);
    check("end_done",  done_out,         1);
    step();
    check("end_done_pulse", done_out, 0);
  endtask

  initial begin
    rst_in          = 1'b1;
    query_start_in  = 1'b0;
    query_done_in   = 1'b0;
    data_valid_in   = 1'b0;
    distance_sq_in  = '0;
    vertex_id_in    = '0;
    result_ready_in = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_in = 1'b0;
    step();
    check_all_zero("idle");

    // 1: basic top-4 of five candidates, ready held high.
    start_query();
    send(32'd50, 16'd1);
    send(32'd10, 16'd2);
    send(32'd30, 16'd3);
    send(32'd20, 16'd4);
    send(32'd40, 16'd5);
    end_query();
    drain(32'hFFFF_FFFF, 32, 1'b0);

    // 2: ties keep arrival order.
    start_query();
    send(32'd7, 16'h000A);
    send(32'd7, 16'h000B);
    check("tie_fill", fill_count_out, 2);
    end_query();
    drain(32'hFFFF_FFFF, 32, 1'b0);

    // 3: empty query -> no beats, done_out the cycle after query_done_in.
    start_query();
    end_query();
    drain(32'hFFFF_FFFF, 32, 1'b0);

    // 4: backpressure 1,0,0,1,1 with ignored inputs during the stall.
    start_query();
    send(32'd300, 16'd31);
    send(32'd100, 16'd32);
    send(32'd200, 16'd33);
    end_query();
    drain(32'b11001, 5, 1'b1);

    // Candidate and query_done_in while IDLE are ignored.
    data_valid_in  = 1'b1;
    query_done_in  = 1'b1;
    distance_sq_in = 32'd1;
    step();
    data_valid_in  = 1'b0;
    query_done_in  = 1'b0;
    check("idle_busy",  busy_out,         0);
    check("idle_valid", result_valid_out, 0);
    step();
    check("idle_done",  done_out,         0);

    // 5a: candidate coincident with query_done_in is included.
    start_query();
    send(32'd5, 16'd1);
    send(32'd9, 16'd2);
    data_valid_in  = 1'b1;
    distance_sq_in = 32'd3;
    vertex_id_in   = 16'd3;
    query_done_in  = 1'b1;
    step();
    data_valid_in  = 1'b0;
    query_done_in  = 1'b0;
    model_insert(32'd3, 16'd3);
    drain(32'hFFFF_FFFF, 32, 1'b0);

    // 5b: start+done together mid-COLLECT restarts; all-ones is insertable.
    start_query();
    send(32'd12, 16'd4);
    query_start_in = 1'b1;
    query_done_in  = 1'b1;
    step();
    query_start_in = 1'b0;
    query_done_in  = 1'b0;
    model.delete();
    check("restart_fill",  fill_count_out,   0);
    check("restart_busy",  busy_out,         1);
    check("restart_valid", result_valid_out, 0);
    send(32'hFFFF_FFFF, 16'd7);
    send(32'd100, 16'd8);
    end_query();
    drain(32'hFFFF_FFFF, 32, 1'b0);

    // 6: reset during beat 1, then a fresh query.
    start_query();
    send(32'd4, 16'd41);
    send(32'd2, 16'd42);
    send(32'd8, 16'd43);
    end_query();
    check("rst_beat0_id", result_id_out, 16'd42);
    result_ready_in = 1'b1;
    step();
    check("rst_beat1_rank", result_rank_out, 1);
    check("rst_beat1_id",   result_id_out,   16'd41);
    rst_in          = 1'b1;
    result_ready_in = 1'b0;
    step();
    check_all_zero("midrst");
    rst_in = 1'b0;
    step();
    check("midrst_done",  done_out,         0);
    check("midrst_valid", result_valid_out, 0);
    start_query();
    send(32'd60, 16'd51);
    send(32'd6,  16'd52);
    end_query();
    drain(32'hFFFF_FFFF, 32, 1'b0);

    // Randomized queries: mix of small (tie-heavy) and full-range distances,
    // idle gaps between candidates, random ready patterns.
    for (int q = 0; q < 12; q++) begin
      int n = $urandom_range(0, 10);
      start_query();
      for (int c = 0; c < n; c++) begin
        logic [31:0] d;
        if ($urandom_range(0, 3) == 0) step();
        d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
        send(d, 16'($urandom));
      end
      end_query();
      drain($urandom, 8, 1'(q % 3 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
